// File: rtl/display_timings_dvi.sv
// display_timings_dvi: pixel-clock raster generator for the DVI/TMDS path.
// Produces sx/sy position counters plus registered de, hsync, vsync, ctrl,
// line and frame markers. All of these describe the same position in the
// same cycle.
// Optional feature: define DISPLAY_TIMINGS_RESTART_EN to add a synchronous
// 'restart' input that forces the raster back to (0,0).
module display_timings_dvi #(
  parameter int          CORDW  = 16,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_n,
`ifdef DISPLAY_TIMINGS_RESTART_EN
  input  logic             restart,
`endif
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [1:0]       ctrl,
  output logic             line,
  output logic             frame
);

  // Window edges are summed at 32 bits so that porches of any size, including
  // zero, cannot wrap before the comparison is made.
  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_RES + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_RES + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);

  // Reject parameter sets the counters cannot represent.
  if (64'(H_TOTAL) > (64'd1 << CORDW)) begin : g_bad_htotal
    $error("H_TOTAL does not fit in CORDW bits");
  end
  if (64'(V_TOTAL) > (64'd1 << CORDW)) begin : g_bad_vtotal
    $error("V_TOTAL does not fit in CORDW bits");
  end
  if (H_SYNC == 0) begin : g_bad_hsync
    $error("H_SYNC must be non-zero");
  end
  if (V_SYNC == 0) begin : g_bad_vsync
    $error("V_SYNC must be non-zero");
  end

  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, line_q, line_d, frame_q, frame_d;
  logic [31:0]      sx32, sy32;

  // Next position first; every marker is then decoded from that next
  // position, so registered markers line up with the registered counters.
  always_comb begin
    sx_d = sx_q + CORDW'(1);
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
    end
`ifdef DISPLAY_TIMINGS_RESTART_EN
    if (restart) begin
      sx_d = '0;
      sy_d = '0;
    end
`endif
    sx32    = 32'(sx_d);
    sy32    = 32'(sy_d);
    de_d    = (sx32 < H_RES) && (sy32 < V_RES);
    hs_d    = ((sx32 >= HS_BEG) && (sx32 < HS_END)) ? H_POL : ~H_POL;
    // sy only moves when sx returns to 0, so vsync edges land on sx==0.
    vs_d    = ((sy32 >= VS_BEG) && (sy32 < VS_END)) ? V_POL : ~V_POL;
    line_d  = (sx_d == '0);
    frame_d = (sx_d == '0) && (sy_d == '0);
  end

  // Raster state and output flops; async reset parks on the last position.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign de    = de_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign ctrl  = {vs_q, hs_q};
  assign line  = line_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_display_timings_dvi.sv
// Bench for display_timings_dvi: small raster (8x6) checked every cycle
// against a position-index model, plus a default 640x480 instance.
module tb_display_timings_dvi;

  localparam int HT = 8, VT = 6, TOT = HT * VT;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b1, rst2_n = 1'b1, restart = 1'b0, chk_en = 1'b0;
  logic [15:0] sx, sy, sx2, sy2;
  logic        de, hsync, vsync, line, frame;
  logic        de2, hsync2, vsync2, line2, frame2;
  logic [1:0]  ctrl, ctrl2;
  int          total = 0, bad = 0;
  int          mpos;

  always #5 clk_pix = ~clk_pix;

  display_timings_dvi #(
    .CORDW(16), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut (
    .clk_pix(clk_pix), .rst_n(rst_n),
`ifdef DISPLAY_TIMINGS_RESTART_EN
    .restart(restart),
`endif
    .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .ctrl(ctrl), .line(line), .frame(frame)
  );

  display_timings_dvi u_vga (
    .clk_pix(clk_pix), .rst_n(rst2_n),
`ifdef DISPLAY_TIMINGS_RESTART_EN
    .restart(1'b0),
`endif
    .sx(sx2), .sy(sy2), .de(de2), .hsync(hsync2), .vsync(vsync2),
    .ctrl(ctrl2), .line(line2), .frame(frame2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: linear index into the frame; position and markers follow by arithmetic.
  always @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) mpos <= TOT - 1;
`ifdef DISPLAY_TIMINGS_RESTART_EN
    else if (restart) mpos <= 0;
`endif
    else mpos <= (mpos + 1) % TOT;
  end

  // Compare every output to the model away from the active edge.
  always @(negedge clk_pix) begin
    if (chk_en) begin
      int ex, ey;
      logic ehs, evs;
      ex  = mpos % HT;
      ey  = mpos / HT;
      ehs = (ex >= 5 && ex < 7) ? 1'b0 : 1'b1;
      evs = (ey == 4) ? 1'b0 : 1'b1;
      chk("sx", 32'(sx), 32'(ex));
      chk("sy", 32'(sy), 32'(ey));
      chk("de", 32'(de), 32'(ex < 4 && ey < 3));
      chk("hsync", 32'(hsync), 32'(ehs));
      chk("vsync", 32'(vsync), 32'(evs));
      chk("ctrl", 32'(ctrl), 32'({evs, ehs}));
      chk("line", 32'(line), 32'(ex == 0));
      chk("frame", 32'(frame), 32'(mpos == 0));
    end
  end

  // Inputs move 3 time units after the rising edge.
  task automatic step();
    @(posedge clk_pix);
    #3;
  endtask

  task automatic wait_pos(input int x, input int y);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (sx == 16'(x) && sy == 16'(y)) hit = 1'b1;
    end
    chk("wait_pos_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    int nframe, nline, fidx, hlow, hfirst;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    #1 chk_en = 1'b1;
    // Reset state of both instances.
    chk("rst_sx", 32'(sx), 32'd7);
    chk("rst_sy", 32'(sy), 32'd5);
    chk("rst_ctrl", 32'(ctrl), 32'd3);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("vga_rst_sx", 32'(sx2), 32'd799);
    chk("vga_rst_sy", 32'(sy2), 32'd524);
    chk("vga_rst_ctrl", 32'(ctrl2), 32'd3);
    step(); step();

    // Release: first edge lands on (0,0) with frame; next frame 48 cycles on.
    rst_n = 1'b1;
    step();
    chk("rel_sx", 32'(sx), 32'd0);
    chk("rel_sy", 32'(sy), 32'd0);
    chk("rel_frame", 32'(frame), 32'd1);
    chk("rel_line", 32'(line), 32'd1);
    chk("rel_de", 32'(de), 32'd1);
    nframe = 0; nline = 0; fidx = -1;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (frame) begin nframe++; if (fidx < 0) fidx = i; end
      if (line) nline++;
    end
    chk("frame_period", 32'(fidx), 32'd48);
    chk("frame_count", 32'(nframe), 32'd1);
    chk("line_count", 32'(nline), 32'd6);

    // Async reset while both syncs are active.
    wait_pos(5, 4);
    chk("pre_hsync", 32'(hsync), 32'd0);
    chk("pre_vsync", 32'(vsync), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_sx", 32'(sx), 32'd7);
    chk("ar_sy", 32'(sy), 32'd5);
    chk("ar_hsync", 32'(hsync), 32'd1);
    chk("ar_vsync", 32'(vsync), 32'd1);
    chk("ar_de", 32'(de), 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef DISPLAY_TIMINGS_RESTART_EN
    wait_pos(3, 2);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_sx", 32'(sx), 32'd0);
    chk("rs_sy", 32'(sy), 32'd0);
    chk("rs_frame", 32'(frame), 32'd1);
    wait_pos(2, 1);
    restart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs3_frame", 32'(frame), 32'd1);
      chk("rs3_pos", 32'({sx, sy}), 32'd0);
    end
    restart = 1'b0;
    step();
    chk("rs_resume", 32'(sx), 32'd1);
`endif

    // Random async resets (and restarts when present) against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
`ifdef DISPLAY_TIMINGS_RESTART_EN
      restart = ($urandom_range(0, 19) == 0);
`endif
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        rst_n = 1'b1;
      end
    end
    restart = 1'b0;
    step();

    // Default 640x480: hsync window over one line, then line wrap.
    rst2_n = 1'b1;
    hlow = 0; hfirst = -1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (!hsync2) begin hlow++; if (hfirst < 0) hfirst = int'(sx2); end
    end
    chk("vga_hs_len", 32'(hlow), 32'd96);
    chk("vga_hs_start", 32'(hfirst), 32'd656);
    step();
    chk("vga_wrap_sx", 32'(sx2), 32'd0);
    chk("vga_wrap_sy", 32'(sy2), 32'd1);
    chk("vga_line", 32'(line2), 32'd1);
    chk("vga_frame", 32'(frame2), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_timings_dvi.md
# display_timings_dvi

Generates the pixel-clock raster for the DVI output path: horizontal/vertical position counters plus registered data-enable, sync, and line/frame markers. Sits directly upstream of the three per-channel TMDS encoders. `de` drives their data-enable input, and `ctrl` drives the blue channel's control input (green/red control tie to 0). Pixel sources use `sx`/`sy`/`de` to produce colour data in the same cycle.

## Interface

**Parameters**
- `CORDW`, 16: width of `sx`/`sy`; must hold H_TOTAL-1 and V_TOTAL-1.
- `H_RES`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch (pixels).
- `H_SYNC`, 96: horizontal sync width (pixels).
- `H_BP`, 48: horizontal back porch (pixels).
- `V_RES`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch (lines).
- `V_SYNC`, 2: vertical sync width (lines).
- `V_BP`, 33: vertical back porch (lines).
- `H_POL`, 0: hsync active level (0 = active-low).
- `V_POL`, 0: vsync active level (0 = active-low).

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_pix`, input, 1: pixel clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
- `sx`, output, CORDW: horizontal position, 0..H_TOTAL-1.
- `sy`, output, CORDW: vertical position, 0..V_TOTAL-1.
- `de`, output, 1: high when the position is in the active area.
- `hsync`, output, 1: horizontal sync at wire polarity.
- `vsync`, output, 1: vertical sync at wire polarity.
- `ctrl`, output, 2: `{vsync, hsync}`, for the blue-channel encoder.
- `line`, output, 1: one-cycle pulse when sx==0.
- `frame`, output, 1: one-cycle pulse when sx==0 and sy==0.
- `restart`, input, 1: present only with `DISPLAY_TIMINGS_RESTART_EN` (see Configuration).

## Operation

- **Totals**
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
- **Position order**
  - Active area is first: sx 0..H_RES-1, then front porch, sync, back porch. Vertical uses the same order.
- **Counters**
  - sx increments every cycle and wraps from H_TOTAL-1 to 0.
  - sy increments only when sx wraps, and wraps from V_TOTAL-1 to 0. Frame wrap occurs when both wrap together.
- **Horizontal sync**
  - hsync is at level H_POL when H_RES+H_FP ≤ sx < H_RES+H_FP+H_SYNC.
  - Otherwise hsync is at ~H_POL.
- **Vertical sync**
  - vsync is at level V_POL when V_RES+V_FP ≤ sy < V_RES+V_FP+V_SYNC, for entire lines.
  - vsync changes only in the cycle where sx==0.
  - Otherwise vsync is at ~V_POL.
- **Data enable**
  - de = (sx < H_RES) && (sy < V_RES).
- **Arithmetic**
  - All comparisons are unsigned at CORDW bits. Sum parameters at 32 bits before comparing.
  - Zero-width porches are legal. The only requirement is that every window boundary remains correct.
- **Parameter check**
  - Elaboration fails (`$error` in an initial or generate check) if H_TOTAL or V_TOTAL exceeds 2^CORDW.
  - Elaboration also fails if H_SYNC or V_SYNC is 0.

## Timing

- **Registered outputs**
  - Every output is a register driven directly from flops, with no combinational path from counters to ports.
- **Alignment**
  - `de`, `hsync`, `vsync`, `ctrl`, `line` and `frame` in cycle t all describe the `sx`/`sy` value present in cycle t. Zero skew between them.
- **Reset values** (rst_n low, asynchronous)
  - sx=H_TOTAL-1, sy=V_TOTAL-1.
  - de=0, hsync=~H_POL, vsync=~V_POL, ctrl={~V_POL,~H_POL}.
  - line=0, frame=0.
- **Reset release**
  - The first rising clk_pix edge with rst_n high produces sx=0, sy=0, de=1, line=1, frame=1.
- **Reset mid-frame**
  - Outputs return to the reset values immediately, without waiting for a clock edge.
  - No partial sync pulse is extended: if sync was active, it goes inactive at once.
- **Encoder latency**
  - The downstream encoders add one cycle. Colour data for (sx,sy) must be presented in the same cycle as that `de`.

## Configuration

- **`DISPLAY_TIMINGS_RESTART_EN` defined**
  - Adds the input `restart`, synchronous to clk_pix.
  - When restart is high at an edge, the next state is sx=0, sy=0 with line=1 and frame=1, regardless of the current position.
  - Holding restart high for N cycles keeps the block at (0,0) with frame=1 for N cycles. Normal counting resumes on the first edge with restart low.
  - restart is ignored while rst_n is low.
- **Not defined**
  - The port does not exist, and the raster free-runs as described above.

## Test plan

Unless stated otherwise, tests use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), polarity 0.

- **Reset release:** release rst_n, then run 48 cycles.
  - First cycle: sx=0, sy=0, frame=1.
  - frame=1 again exactly 48 cycles later. line=1 every 8 cycles.
- **Horizontal sync:** observe one line.
  - hsync=0 exactly at sx=5,6; otherwise 1.
  - de=1 at sx=0..3 when sy<3.
- **Vertical sync:** observe one frame.
  - vsync=0 for all 8 cycles of sy=4, falling at sx=0 of that line.
  - ctrl=2'b01 during sy=4 outside sx 5..6.
- **Asynchronous reset mid-sync:** assert rst_n low mid-clock at sx=5, sy=4.
  - Outputs immediately show sx=7, sy=5, hsync=1, vsync=1, de=0.
- **Default 640x480:** check totals.
  - frame period is 800×525 = 420000 cycles.
  - hsync low for 96 cycles, starting at sx=656.
- **Restart (`DISPLAY_TIMINGS_RESTART_EN`):** pulse restart at sx=3, sy=2.
  - Next cycle: sx=0, sy=0, frame=1.
  - A 3-cycle restart pulse holds (0,0) for 3 cycles.
